// File: rtl/fetch.sv
// Instruction fetch stage: owns the pc and talks to imem with valid/ready.
// Stalls the pipeline while waiting and halts on fault, misalign or timeout.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013,
  parameter logic [15:0] TIMEOUT  = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        override,
  input  logic [31:0] newpc,
  input  logic        fault,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] insn,
  output logic [31:0] outpc,
  output logic        hlt,
  output logic        halted,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] outpc_q, outpc_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;
  logic        timeout_hit;

  // Last permitted wait cycle; a zero TIMEOUT never fires.
  assign timeout_hit = (TIMEOUT != 16'd0) &&
                       (wait_cnt_q == TIMEOUT - 16'd1);

  assign imem_valid = (state_q == REQ);
  assign imem_addr  = pc_q;
  assign hlt        = (state_q != REQ) | ~imem_ready;
  assign halted     = (state_q == HALTED);
  assign insn       = insn_q;
  assign outpc      = outpc_q;
  assign bus_err    = bus_err_q;
  assign misalign   = misalign_q;

  // Next state: wait/accept handling with fault > override > sequential.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    insn_d     = insn_q;
    outpc_d    = outpc_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    misalign_d = misalign_q;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (!imem_ready) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          if (timeout_hit) begin
            state_d   = HALTED;
            bus_err_d = 1'b1;
          end
        end else begin
          insn_d     = imem_rdata;
          outpc_d    = pc_q;
          wait_cnt_d = 16'd0;
          if (fault) begin
            state_d = HALTED;
          end else if (override && (newpc[1:0] != 2'b00)) begin
            state_d    = HALTED;
            misalign_d = 1'b1;
          end else if (override) begin
            pc_d = newpc;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = HALTED;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      insn_q     <= NOP;
      outpc_q    <= RESET_PC;
      wait_cnt_q <= 16'd0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      insn_q     <= insn_d;
      outpc_q    <= outpc_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: handshake addresses and per-cycle status.
// Two instances: TIMEOUT=4 for most checks, TIMEOUT=0 for the no-timeout run.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, override, fault, imem_ready;
  logic [31:0] newpc, imem_rdata;
  logic        imem_valid, hlt, halted, bus_err, misalign;
  logic [31:0] imem_addr, insn, outpc;

  logic        rst2 = 1'b0;
  logic        v2, h2, hd2, be2, mi2;
  logic [31:0] a2, i2, o2;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0), .NOP(NOP), .TIMEOUT(16'd4)) dut (
    .clk(clk), .rst(rst), .override(override), .newpc(newpc),
    .fault(fault), .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .insn(insn),
    .outpc(outpc), .hlt(hlt), .halted(halted), .bus_err(bus_err),
    .misalign(misalign)
  );

  fetch #(.RESET_PC(32'h0), .NOP(NOP), .TIMEOUT(16'd0)) dut2 (
    .clk(clk), .rst(rst2), .override(1'b0), .newpc(32'h0),
    .fault(1'b0), .imem_valid(v2), .imem_addr(a2),
    .imem_ready(1'b0), .imem_rdata(32'h0), .insn(i2),
    .outpc(o2), .hlt(h2), .halted(hd2), .bus_err(be2),
    .misalign(mi2)
  );

  typedef struct packed {
    logic        id;
    logic [4:0]  fl;
    logic [31:0] addr;
    logic [31:0] insn;
    logic [31:0] outpc;
  } st_t;

  st_t         sq[$];
  logic [31:0] fq[$];
  logic [31:0] e_insn, e_outpc;
  logic        done = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void cmp(input string nm,
                              input logic [31:0] got,
                              input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endfunction

  // fl = {valid, hlt, halted, bus_err, misalign}
  function automatic void exp_st(input logic id, input logic [4:0] fl,
                                 input logic [31:0] a);
    if (id) sq.push_back({id, fl, a, NOP, 32'h0});
    else    sq.push_back({id, fl, a, e_insn, e_outpc});
  endfunction

  // Monitor: compares whenever a handshake or queued status is due.
  always @(negedge clk) begin
    logic [4:0]  gf;
    logic [31:0] ga, gi, go;
    st_t         s;
    if (imem_valid && imem_ready) begin
      if (fq.size() == 0) begin
        cmp("unexpected_req", imem_addr, 32'hFFFF_FFFF);
      end else begin
        cmp("req_addr", imem_addr, fq.pop_front());
      end
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      if (s.id) begin
        gf = {v2, h2, hd2, be2, mi2};
        ga = a2; gi = i2; go = o2;
      end else begin
        gf = {imem_valid, hlt, halted, bus_err, misalign};
        ga = imem_addr; gi = insn; go = outpc;
      end
      cmp("imem_valid", {31'd0, gf[4]}, {31'd0, s.fl[4]});
      cmp("hlt",        {31'd0, gf[3]}, {31'd0, s.fl[3]});
      cmp("halted",     {31'd0, gf[2]}, {31'd0, s.fl[2]});
      cmp("bus_err",    {31'd0, gf[1]}, {31'd0, s.fl[1]});
      cmp("misalign",   {31'd0, gf[0]}, {31'd0, s.fl[0]});
      cmp("imem_addr", ga, s.addr);
      cmp("insn", gi, s.insn);
      cmp("outpc", go, s.outpc);
    end
    if (done) begin
      cmp("req_left", fq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r, input logic rdy,
                     input logic [31:0] rd, input logic ov,
                     input logic [31:0] np, input logic f);
    rst = r; imem_ready = rdy; imem_rdata = rd;
    override = ov; newpc = np; fault = f;
  endtask

  task automatic fetch_ok(input logic [31:0] a, input logic [31:0] d,
                          input logic ov = 1'b0,
                          input logic [31:0] np = 32'h0,
                          input logic f = 1'b0);
    drv(1'b1, 1'b1, d, ov, np, f);
    fq.push_back(a);
    exp_st(1'b0, 5'b10000, a);
    step();
    e_insn = d;
    e_outpc = a;
  endtask

  task automatic waitc(input logic [31:0] a, input logic ov = 1'b0,
                       input logic [31:0] np = 32'h0);
    drv(1'b1, 1'b0, 32'hBAD0_BAD0, ov, np, 1'b0);
    exp_st(1'b0, 5'b11000, a);
    step();
  endtask

  task automatic halt_cyc(input logic [31:0] a, input logic be,
                          input logic mi);
    drv(1'b1, 1'b1, 32'h5A5A_5A5A, 1'b1, 32'h300, 1'b1);
    exp_st(1'b0, {3'b011, be, mi}, a);
    step();
  endtask

  task automatic rst_pulse();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    e_insn = NOP;
    e_outpc = 32'h0;
    drv(1'b1, 1'b1, 32'h7777_7777, 1'b0, 32'h0, 1'b0);
    exp_st(1'b0, 5'b01000, 32'h0);
    step();
  endtask

  initial begin
    e_insn = NOP;
    e_outpc = 32'h0;
    // Reset sequence with ready tied high
    drv(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      exp_st(1'b0, 5'b01000, 32'h0);
      step();
    end
    drv(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    exp_st(1'b0, 5'b01000, 32'h0);
    step();
    fetch_ok(32'h0, 32'h11);
    fetch_ok(32'h4, 32'h22);
    fetch_ok(32'h8, 32'h33);
    fetch_ok(32'hC, 32'h44);
    // Redirect: ignored while waiting, taken on accept
    waitc(32'h10, 1'b1, 32'h100);
    waitc(32'h10, 1'b1, 32'h100);
    fetch_ok(32'h10, 32'h55, 1'b1, 32'h100);
    fetch_ok(32'h100, 32'h66);
    // Fault beats override
    fetch_ok(32'h104, 32'h77, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 3; i++) halt_cyc(32'h104, 1'b0, 1'b0);
    // Wait states on 0x8
    rst_pulse();
    fetch_ok(32'h0, 32'hB00);
    fetch_ok(32'h4, 32'hB04);
    for (int i = 0; i < 3; i++) waitc(32'h8);
    fetch_ok(32'h8, 32'hDEAD_BEEF);
    fetch_ok(32'hC, 32'hB0C);
    // Misaligned redirect
    fetch_ok(32'h10, 32'hB10, 1'b1, 32'h102);
    for (int i = 0; i < 2; i++) halt_cyc(32'h10, 1'b0, 1'b1);
    // Wrap from top of address space
    rst_pulse();
    fetch_ok(32'h0, 32'hC00, 1'b1, 32'hFFFF_FFFC);
    fetch_ok(32'hFFFF_FFFC, 32'hC01);
    fetch_ok(32'h0, 32'hC02);
    // Timeout after four wait cycles
    for (int i = 0; i < 4; i++) waitc(32'h4);
    for (int i = 0; i < 2; i++) halt_cyc(32'h4, 1'b1, 1'b0);
    // Reset mid-wait clears the counter; late ready ignored in BOOT
    rst_pulse();
    fetch_ok(32'h0, 32'hE00);
    waitc(32'h4);
    waitc(32'h4);
    drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp_st(1'b0, 5'b11000, 32'h4);
    step();
    e_insn = NOP;
    e_outpc = 32'h0;
    drv(1'b1, 1'b1, 32'hE1E1_E1E1, 1'b0, 32'h0, 1'b0);
    exp_st(1'b0, 5'b01000, 32'h0);
    step();
    for (int i = 0; i < 4; i++) waitc(32'h0);
    halt_cyc(32'h0, 1'b1, 1'b0);
    // TIMEOUT=0 instance waits 5000 cycles without halting
    rst2 = 1'b1;
    exp_st(1'b1, 5'b01000, 32'h0);
    step();
    for (int i = 0; i < 5000; i++) begin
      if ((i % 1000) == 0 || i == 4999) exp_st(1'b1, 5'b11000, 32'h0);
      step();
    end
    done = 1'b1;
  end

endmodule
